cmd_frame_rx: RTL
=================

Name: cmd_frame_rx

Overview:
- Device-side end of the remote command link: receives 3-byte command frames (cmd, data[15:8], data[7:0]) over serial RX and presents them as a 24-bit command with a ready flag.
- Transmits 1-byte responses (e.g. 0xA5 ack) back on TX.
- Instantiates the team's existing 8-bit UART transceiver and wraps it with frame-assembly and response-holding logic.
- Sits between the serial pins and the command processor.

Parameters:
- TIMEOUT_CYCLES, 22'd2_000_000 — inter-byte timeout in clk cycles; used only with CMD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RX  input  1  serial data in
- TX  output  1  serial data out
- cmd  output  8  captured command byte
- data  output  16  captured data, {byte2, byte3}
- cmd_rdy  output  1  full frame captured; held until cleared
- clr_cmd_rdy  input  1  consumer pulse; knocks down cmd_rdy
- send_resp  input  1  one-cycle request to transmit resp
- resp  input  8  response byte, sampled when send_resp is high
- resp_sent  output  1  one-cycle pulse when the response byte's stop bit completes
- frame_err  output  1  one-cycle pulse on timeout abort; constant 0 without CMD_TIMEOUT_EN

Behaviour:
- Reset values:
  - FSM in IDLE.
  - cmd = 0x00, data = 0x0000.
  - cmd_rdy = 0, resp_sent = 0, frame_err = 0.
  - TX idles high (UART reset state).
  - Holding register empty.
- Receive FSM, states IDLE, GET_HI, GET_LO:
  - IDLE: on UART rx_rdy, latch rx_data into the cmd shadow register, pulse clr_rx_rdy in the same cycle, clear cmd_rdy, go to GET_HI.
  - GET_HI: on rx_rdy, latch into data_hi, pulse clr_rx_rdy, go to GET_LO.
  - GET_LO: on rx_rdy, latch into data_lo, pulse clr_rx_rdy, go to IDLE, and set cmd_rdy.
- Output timing:
  - cmd and data outputs update in the same cycle cmd_rdy rises; they are registered, not combinational from shadows.
  - Latency: cmd_rdy is high one clk after the UART rx_rdy for the third byte.
- cmd_rdy rules:
  - Set: on frame completion. Cleared by clr_cmd_rdy, or by the first byte of the next frame.
  - If set and clr_cmd_rdy occur in the same cycle, set wins.
  - cmd and data stay stable while cmd_rdy = 1, even while a new frame is partially received; new bytes go to the shadow registers.
- Response path:
  - send_resp with the transmitter idle: trmt asserted the next cycle with tx_data = resp.
  - send_resp while a byte is in flight: resp goes into a 1-deep holding register and is sent on tx_done.
  - send_resp while the holding register is already full: the new value overwrites the held byte.
  - resp_sent pulses on each tx_done.
  - The response path is independent of the receive FSM; full duplex is legal.
- Reset mid-frame: partial bytes are discarded, FSM returns to IDLE, any in-flight TX is aborted, TX returns high.
- Back-to-back frames: a byte arriving in the same cycle as frame completion is impossible (UART byte time is much greater than 1 cycle), so no special handling is needed.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A counter resets on every rx_rdy and counts while in GET_HI or GET_LO.
  - When the counter reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, pulses frame_err for 1 cycle, and discards the shadow registers.
  - cmd, data and cmd_rdy are unaffected by the abort.
- Not defined:
  - No counter is built; frame_err is tied to 0.
  - A partial frame waits indefinitely.

Decomposition:
- Package cmd_frame_pkg holds:
  - the rx_state_t enum (IDLE, GET_HI, GET_LO);
  - constants FRAME_BYTES = 3 and ACK = 8'hA5, shared with the remote-side driver.
- Sub-module: resp_tx_hold (holding register plus trmt sequencing around the UART TX).
- The UART instance and the receive FSM stay in the top level.

Test Plan:
- Drive bytes 0x02, 0x12, 0x34 on RX → cmd = 0x02, data = 0x1234, cmd_rdy = 1 one clk after the third rx_rdy. clr_cmd_rdy → cmd_rdy = 0.
- Frame 0x05/0xBEEF followed by a second frame 0x06/0x0001 without clearing → cmd_rdy drops at the first byte of frame 2, cmd/data hold 0x05/0xBEEF until it completes, then show 0x06/0x0001.
- send_resp with resp = 0xA5, then send_resp with 0x5A one cycle later → TX serializes 0xA5 then 0x5A back-to-back; resp_sent pulses twice.
- Assert rst_n low after 2 of 3 bytes, then send 0x07, 0x00, 0x10 → cmd = 0x07, data = 0x0010, no stale byte.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES = 1000: send one byte, then idle 1000 cycles → frame_err pulses; the next full frame 0x03/0xAAAA captures correctly.
- Full duplex: send_resp 0x33 while the 3-byte frame 0x04/0x5555 is arriving → both complete correctly.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command-frame link. The frame length and
// ack byte are also used by the remote-side driver, so keep them in step.
package cmd_frame_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GET_HI = 2'd1,
      GET_LO = 2'd2
   } rx_state_t;

   localparam int         FRAME_BYTES = 3;
   localparam logic [7:0] ACK         = 8'hA5;

endpackage

// File: rtl/resp_tx_hold.sv
// Response sequencing in front of the UART transmitter. A request with the
// transmitter idle starts immediately; a request while a byte is in flight
// parks in a one-deep holding register (later requests overwrite it) and is
// launched on the next tx_done.
module resp_tx_hold (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_send_resp,
   input  logic [7:0] i_resp,
   input  logic       i_tx_done,
   output logic       o_trmt,
   output logic [7:0] o_tx_data,
   output logic       o_resp_sent
);

   logic       r_busy;
   logic       r_trmt;
   logic [7:0] r_tx_data;
   logic [7:0] r_hold;
   logic       r_hold_vld;

   // r_busy covers the span from trmt issue to tx_done, so a request in the
   // trmt cycle itself is already treated as "in flight".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= 1'b0;
         r_trmt     <= 1'b0;
         r_tx_data  <= '0;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
      end else begin
         r_trmt <= 1'b0;
         if (i_tx_done) begin
            if (i_send_resp) begin
               r_trmt     <= 1'b1;
               r_tx_data  <= i_resp;
               r_hold_vld <= 1'b0;
            end else if (r_hold_vld) begin
               r_trmt     <= 1'b1;
               r_tx_data  <= r_hold;
               r_hold_vld <= 1'b0;
            end else begin
               r_busy <= 1'b0;
            end
         end else if (i_send_resp) begin
            if (r_busy) begin
               r_hold     <= i_resp;
               r_hold_vld <= 1'b1;
            end else begin
               r_trmt    <= 1'b1;
               r_tx_data <= i_resp;
               r_busy    <= 1'b1;
            end
         end
      end
   end

   assign o_trmt      = r_trmt;
   assign o_tx_data   = r_tx_data;
   assign o_resp_sent = i_tx_done;

endmodule

// File: rtl/uart.sv
// 8N1 UART transceiver. o_rx_rdy is held until i_clr_rx_rdy or the next start
// bit. o_tx_done is a one-cycle pulse when the stop bit has been fully driven.
module uart #(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic       o_tx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_rdy,
   input  logic       i_clr_rx_rdy,
   input  logic       i_trmt,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_done
);

   localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

   logic        r_rx_s1, r_rx_s2;
   logic        r_rx_busy;
   logic [15:0] r_rx_baud;
   logic [3:0]  r_rx_bits;
   logic [7:0]  r_rx_shift;
   logic        r_rx_rdy;
   logic        w_rx_last;

   logic        r_tx_busy;
   logic [15:0] r_tx_baud;
   logic [3:0]  r_tx_bits;
   logic [9:0]  r_tx_shift;
   logic        r_tx_done;

   // Two-flop synchroniser on the asynchronous serial input; line idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= i_rx;
         r_rx_s2 <= r_rx_s1;
      end
   end

   // Stop-bit sample point; the byte is complete here.
   assign w_rx_last = r_rx_busy && (r_rx_baud == '0) && (r_rx_bits == 4'd9);

   // Receive sequencer: wait half a bit after the start edge, then sample at
   // each bit centre. Start and data samples shift in; the stop sample does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_busy  <= 1'b0;
         r_rx_baud  <= '0;
         r_rx_bits  <= '0;
         r_rx_shift <= '0;
      end else if (!r_rx_busy) begin
         if (!r_rx_s2) begin
            r_rx_busy <= 1'b1;
            r_rx_baud <= HALF_M1;
            r_rx_bits <= '0;
         end
      end else if (r_rx_baud == '0) begin
         r_rx_baud <= DIV_M1;
         r_rx_bits <= r_rx_bits + 4'd1;
         if (r_rx_bits != 4'd9)
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
         else
            r_rx_busy <= 1'b0;
      end else begin
         r_rx_baud <= r_rx_baud - 16'd1;
      end
   end

   // Ready flag: set on byte completion, dropped by the consumer or a new start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rx_rdy <= 1'b0;
      else if (w_rx_last)
         r_rx_rdy <= 1'b1;
      else if (i_clr_rx_rdy || (!r_rx_busy && !r_rx_s2))
         r_rx_rdy <= 1'b0;
   end

   // Transmit sequencer: shift out {stop, data, start} LSB first, one bit per
   // baud period, pulsing done after the stop bit's full period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_busy  <= 1'b0;
         r_tx_baud  <= '0;
         r_tx_bits  <= '0;
         r_tx_shift <= '1;
         r_tx_done  <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         if (!r_tx_busy) begin
            if (i_trmt) begin
               r_tx_busy  <= 1'b1;
               r_tx_baud  <= DIV_M1;
               r_tx_bits  <= '0;
               r_tx_shift <= {1'b1, i_tx_data, 1'b0};
            end
         end else if (r_tx_baud == '0) begin
            r_tx_baud  <= DIV_M1;
            r_tx_bits  <= r_tx_bits + 4'd1;
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            if (r_tx_bits == 4'd9) begin
               r_tx_busy <= 1'b0;
               r_tx_done <= 1'b1;
            end
         end else begin
            r_tx_baud <= r_tx_baud - 16'd1;
         end
      end
   end

   assign o_tx      = r_tx_shift[0];
   assign o_rx_data = r_rx_shift;
   assign o_rx_rdy  = r_rx_rdy;
   assign o_tx_done = r_tx_done;

endmodule

// File: rtl/cmd_frame_rx.sv
// Device-side command link: assembles 3-byte frames (cmd, data hi, data lo)
// from the UART into registered cmd/data outputs with a sticky cmd_rdy, and
// forwards response bytes to the UART transmitter.
// Optional build macro CMD_TIMEOUT_EN adds an inter-byte timeout that aborts
// a partial frame and pulses frame_err.
module cmd_frame_rx
   import cmd_frame_pkg::*;
#(
   parameter logic [21:0] TIMEOUT_CYCLES = 22'd2_000_000,
   parameter int unsigned BAUD_DIV       = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   input  logic [7:0]  resp,
   output logic        resp_sent,
   output logic        frame_err
);

   rx_state_t   r_state, w_next_state;
   logic        w_rx_rdy;
   logic [7:0]  w_rx_data;
   logic        w_clr_rx_rdy;
   logic        w_trmt;
   logic [7:0]  w_tx_data;
   logic        w_tx_done;
   logic        w_ld_cmd, w_ld_hi, w_ld_lo;
   logic        w_timeout;

   logic [7:0]  r_cmd_sh;
   logic [7:0]  r_hi_sh;
   logic [7:0]  r_cmd;
   logic [15:0] r_data;
   logic        r_cmd_rdy;

   uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rx         (RX),
      .o_tx         (TX),
      .o_rx_data    (w_rx_data),
      .o_rx_rdy     (w_rx_rdy),
      .i_clr_rx_rdy (w_clr_rx_rdy),
      .i_trmt       (w_trmt),
      .i_tx_data    (w_tx_data),
      .o_tx_done    (w_tx_done)
   );

   resp_tx_hold u_resp_tx_hold (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_send_resp (send_resp),
      .i_resp      (resp),
      .i_tx_done   (w_tx_done),
      .o_trmt      (w_trmt),
      .o_tx_data   (w_tx_data),
      .o_resp_sent (resp_sent)
   );

`ifdef CMD_TIMEOUT_EN
   logic [21:0] r_to_cnt;
   logic        r_frame_err;

   // A byte arriving in the expiry cycle wins over the timeout.
   assign w_timeout = (r_state != IDLE) && !w_rx_rdy &&
                      (r_to_cnt == TIMEOUT_CYCLES - 22'd1);

   // Inter-byte counter: runs only mid-frame, restarts on every received byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_to_cnt <= '0;
      else if (w_rx_rdy || (r_state == IDLE) || w_timeout)
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + 22'd1;
   end

   // One-cycle abort indication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_frame_err <= 1'b0;
      else
         r_frame_err <= w_timeout;
   end

   assign frame_err = r_frame_err;
`else
   // The timeout parameter stays in the interface so both builds instantiate
   // identically; without the feature the error output is permanently low.
   assign w_timeout = 1'b0;
   assign frame_err = 1'b0 & (TIMEOUT_CYCLES != 22'd0);
`endif

   // Receive FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Next state and per-byte load strobes; each accepted byte is acknowledged
   // back to the UART in the same cycle.
   always_comb begin
      w_next_state = r_state;
      w_clr_rx_rdy = 1'b0;
      w_ld_cmd     = 1'b0;
      w_ld_hi      = 1'b0;
      w_ld_lo      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rx_rdy) begin
               w_ld_cmd     = 1'b1;
               w_clr_rx_rdy = 1'b1;
               w_next_state = GET_HI;
            end
         end
         GET_HI: begin
            if (w_rx_rdy) begin
               w_ld_hi      = 1'b1;
               w_clr_rx_rdy = 1'b1;
               w_next_state = GET_LO;
            end else if (w_timeout) begin
               w_next_state = IDLE;
            end
         end
         GET_LO: begin
            if (w_rx_rdy) begin
               w_ld_lo      = 1'b1;
               w_clr_rx_rdy = 1'b1;
               w_next_state = IDLE;
            end else if (w_timeout) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Shadow capture of the first two bytes; an aborted frame wipes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_sh <= '0;
         r_hi_sh  <= '0;
      end else if (w_timeout) begin
         r_cmd_sh <= '0;
         r_hi_sh  <= '0;
      end else begin
         if (w_ld_cmd) r_cmd_sh <= w_rx_data;
         if (w_ld_hi)  r_hi_sh  <= w_rx_data;
      end
   end

   // Published outputs change only on frame completion, so they stay stable
   // while the next frame fills the shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd  <= '0;
         r_data <= '0;
      end else if (w_ld_lo) begin
         r_cmd  <= r_cmd_sh;
         r_data <= {r_hi_sh, w_rx_data};
      end
   end

   // Sticky ready: completion has priority over the consumer clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cmd_rdy <= 1'b0;
      else if (w_ld_lo)
         r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || w_ld_cmd)
         r_cmd_rdy <= 1'b0;
   end

   assign cmd     = r_cmd;
   assign data    = r_data;
   assign cmd_rdy = r_cmd_rdy;

endmodule
